// File: rtl/dr_mem_arb_pkg.sv
// Shared types for the directory-to-memory arbiter: payload field widths,
// memory request kinds and the internal grant selector.
package dr_mem_arb_pkg;

    localparam int DRID_W  = 6;
    localparam int CMD_W   = 4;
    localparam int PADDR_W = 32;
    localparam int LINE_W  = 64;

    typedef logic [DRID_W-1:0]  DR_reqid_type;
    typedef logic [CMD_W-1:0]   SC_cmd_type;
    typedef logic [PADDR_W-1:0] SC_paddr_type;
    typedef logic [LINE_W-1:0]  SC_line_type;

    typedef enum logic [1:0] {
        MK_REQ = 2'd0,
        MK_WB  = 2'd1,
        MK_PF  = 2'd2
    } DR_memkind_type;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REQ  = 2'd1,
        GNT_WB   = 2'd2,
        GNT_PF   = 2'd3
    } grant_type;

endpackage

// File: rtl/dr_mem_arb_if.sv
// Bundle of the three directory-side input streams, the snooped ack channel
// and the merged memory request channel.
interface dr_mem_arb_if;
    import dr_mem_arb_pkg::*;

    logic           drtomem_req_valid;
    logic           drtomem_req_retry;
    DR_reqid_type   drtomem_req_drid;
    SC_cmd_type     drtomem_req_cmd;
    SC_paddr_type   drtomem_req_paddr;

    logic           drtomem_wb_valid;
    logic           drtomem_wb_retry;
    SC_line_type    drtomem_wb_line;
    SC_paddr_type   drtomem_wb_paddr;

    logic           drtomem_pfreq_valid;
    logic           drtomem_pfreq_retry;
    SC_paddr_type   drtomem_pfreq_paddr;

    logic           memtodr_ack_valid;
    logic           memtodr_ack_retry;

    logic           mem_req_valid;
    logic           mem_req_retry;
    DR_memkind_type mem_req_kind;
    DR_reqid_type   mem_req_drid;
    SC_cmd_type     mem_req_cmd;
    SC_paddr_type   mem_req_paddr;
    SC_line_type    mem_req_line;

    modport master (
        output drtomem_req_valid, drtomem_req_drid, drtomem_req_cmd, drtomem_req_paddr,
        output drtomem_wb_valid, drtomem_wb_line, drtomem_wb_paddr,
        output drtomem_pfreq_valid, drtomem_pfreq_paddr,
        output memtodr_ack_valid, memtodr_ack_retry, mem_req_retry,
        input  drtomem_req_retry, drtomem_wb_retry, drtomem_pfreq_retry,
        input  mem_req_valid, mem_req_kind, mem_req_drid, mem_req_cmd,
        input  mem_req_paddr, mem_req_line
    );

    modport slave (
        input  drtomem_req_valid, drtomem_req_drid, drtomem_req_cmd, drtomem_req_paddr,
        input  drtomem_wb_valid, drtomem_wb_line, drtomem_wb_paddr,
        input  drtomem_pfreq_valid, drtomem_pfreq_paddr,
        input  memtodr_ack_valid, memtodr_ack_retry, mem_req_retry,
        output drtomem_req_retry, drtomem_wb_retry, drtomem_pfreq_retry,
        output mem_req_valid, mem_req_kind, mem_req_drid, mem_req_cmd,
        output mem_req_paddr, mem_req_line
    );

endinterface

// File: rtl/dr_pfreq_fifo.sv
// Drop-oldest circular prefetch queue: a push into a full queue without a
// pop overwrites the oldest entry and pulses drop.
module dr_pfreq_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign drop  = push && full && !pop;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            // an overwrite retires the oldest entry exactly like a pop
            if (pop || drop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dr_mem_arb.sv
// Merges demand requests, writebacks and prefetches into one registered
// memory request slot with WB burst limiting and demand-read credits.
module dr_mem_arb
    import dr_mem_arb_pkg::*;
#(
    parameter int PF_DEPTH  = 4,
    parameter int MAX_OUTST = 8,
    parameter int WB_BURST  = 4
) (
    input  logic        clk,
    input  logic        reset,
    dr_mem_arb_if.slave bus
);
    localparam int CRED_W = $clog2(MAX_OUTST + 1);
    localparam int CNT_W  = $clog2(WB_BURST + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WB_BURST);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_wb(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CRED_W-1:0] next_credits(input logic [CRED_W-1:0] c,
                                                       input logic take, input logic give);
        if (take && !give)
            return c - CRED_W'(1);
        if (give && !take && c != CRED_MAX)
            return c + CRED_W'(1);
        return c;
    endfunction

    logic [CRED_W-1:0] credits;
    logic [CNT_W-1:0]  wb_cnt;
    logic [15:0]       pf_drop_cnt;

    logic              vld_p1;
    DR_memkind_type    kind_p1;
    DR_reqid_type      drid_p1;
    SC_cmd_type        cmd_p1;
    SC_paddr_type      paddr_p1;
    SC_line_type       line_p1;

    logic              slot_free;
    logic              ack_xfer;
    logic              req_elig;
    grant_type         grant;
    logic              pf_full;
    logic              pf_empty;
    logic              pf_drop;
    SC_paddr_type      pf_head;

    dr_pfreq_fifo #(.DEPTH(PF_DEPTH), .DATA_W(PADDR_W)) u_pf (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.drtomem_pfreq_valid),
        .push_data (bus.drtomem_pfreq_paddr),
        .pop       (grant == GNT_PF),
        .head      (pf_head),
        .full      (pf_full),
        .empty     (pf_empty),
        .drop      (pf_drop)
    );

    // A same-cycle ack funds a REQ even at zero credits, so a grant and an ack
    // together leave the count unchanged.
    always_comb begin
        slot_free = !vld_p1 || !bus.mem_req_retry;
        ack_xfer  = bus.memtodr_ack_valid && !bus.memtodr_ack_retry;
        req_elig  = bus.drtomem_req_valid && ((credits != '0) || ack_xfer);
        grant     = GNT_NONE;
        if (slot_free) begin
            if (bus.drtomem_wb_valid && !(req_elig && wb_cnt == CNT_MAX))
                grant = GNT_WB;
            else if (req_elig)
                grant = GNT_REQ;
            else if (!pf_empty)
                grant = GNT_PF;
        end
    end

    assign bus.drtomem_req_retry   = (grant != GNT_REQ);
    assign bus.drtomem_wb_retry    = (grant != GNT_WB);
    assign bus.drtomem_pfreq_retry = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits     <= CRED_MAX;
            wb_cnt      <= '0;
            pf_drop_cnt <= '0;
        end else begin
            credits <= next_credits(credits, grant == GNT_REQ, ack_xfer);
            if (!bus.drtomem_req_valid || grant == GNT_REQ)
                wb_cnt <= '0;
            else if (grant == GNT_WB && req_elig)
                wb_cnt <= sat_inc_wb(wb_cnt);
            if (pf_drop)
                pf_drop_cnt <= sat_inc16(pf_drop_cnt);
        end
    end

    // p1: registered output slot, loaded whenever it is free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            kind_p1  <= MK_REQ;
            drid_p1  <= '0;
            cmd_p1   <= '0;
            paddr_p1 <= '0;
            line_p1  <= '0;
        end else if (slot_free) begin
            vld_p1 <= (grant != GNT_NONE);
            unique case (grant)
                GNT_REQ: begin
                    kind_p1  <= MK_REQ;
                    drid_p1  <= bus.drtomem_req_drid;
                    cmd_p1   <= bus.drtomem_req_cmd;
                    paddr_p1 <= bus.drtomem_req_paddr;
                    line_p1  <= '0;
                end
                GNT_WB: begin
                    kind_p1  <= MK_WB;
                    drid_p1  <= '0;
                    cmd_p1   <= '0;
                    paddr_p1 <= bus.drtomem_wb_paddr;
                    line_p1  <= bus.drtomem_wb_line;
                end
                GNT_PF: begin
                    kind_p1  <= MK_PF;
                    drid_p1  <= '0;
                    cmd_p1   <= '0;
                    paddr_p1 <= pf_head;
                    line_p1  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req_valid = vld_p1;
    assign bus.mem_req_kind  = kind_p1;
    assign bus.mem_req_drid  = drid_p1;
    assign bus.mem_req_cmd   = cmd_p1;
    assign bus.mem_req_paddr = paddr_p1;
    assign bus.mem_req_line  = line_p1;

    assert property (@(posedge clk) disable iff (!reset) !(ack_xfer && credits == CRED_MAX));
    assert property (@(posedge clk) disable iff (!reset) pf_drop |-> pf_full);

endmodule

// File: tb/tb_dr_mem_arb.sv
// Bench for dr_mem_arb: queue-based behavioural model checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_dr_mem_arb;
    import dr_mem_arb_pkg::*;

    localparam int PF_DEPTH  = 4;
    localparam int MAX_OUTST = 8;
    localparam int WB_BURST  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dr_mem_arb_if bus();

    dr_mem_arb #(.PF_DEPTH(PF_DEPTH), .MAX_OUTST(MAX_OUTST), .WB_BURST(WB_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model state: what the DUT must hold during the current cycle
    bit             m_vld;
    DR_memkind_type m_kind;
    DR_reqid_type   m_drid;
    SC_cmd_type     m_cmd;
    SC_paddr_type   m_paddr;
    SC_line_type    m_line;
    int             m_credits;
    int             m_wbcnt;
    int             m_drops;
    SC_paddr_type   pfq[$];
    bit             req_held, wb_held;
    DR_memkind_type log_kind[$];
    SC_paddr_type   log_paddr[$];
    SC_paddr_type   pf_list[$];

    int  g;
    bit  free_s, ack_x, req_ok;

    always @(negedge clk) begin
        if (!reset) begin
            m_vld = 0; m_kind = MK_REQ; m_drid = '0; m_cmd = '0; m_paddr = '0; m_line = '0;
            m_credits = MAX_OUTST; m_wbcnt = 0; m_drops = 0;
            pfq.delete();
            req_held = 0; wb_held = 0;
            check("rst_valid", 64'(bus.mem_req_valid), 64'(0));
            check("rst_paddr", 64'(bus.mem_req_paddr), 64'(0));
            check("rst_credits", 64'(dut.credits), 64'(MAX_OUTST));
        end else begin
            check("out_valid", 64'(bus.mem_req_valid), 64'(m_vld));
            if (m_vld) begin
                check("out_kind", 64'(bus.mem_req_kind), 64'(m_kind));
                check("out_drid", 64'(bus.mem_req_drid), 64'(m_drid));
                check("out_cmd", 64'(bus.mem_req_cmd), 64'(m_cmd));
                check("out_paddr", 64'(bus.mem_req_paddr), 64'(m_paddr));
                check("out_line", 64'(bus.mem_req_line), 64'(m_line));
            end
            check("credits", 64'(dut.credits), 64'(m_credits));
            check("drop_cnt", 64'(dut.pf_drop_cnt), 64'(m_drops));

            ack_x  = bus.memtodr_ack_valid && !bus.memtodr_ack_retry;
            free_s = !m_vld || !bus.mem_req_retry;
            req_ok = bus.drtomem_req_valid && (m_credits > 0 || ack_x);
            g = 0;
            if (free_s) begin
                if (bus.drtomem_wb_valid && !(req_ok && m_wbcnt == WB_BURST)) g = 2;
                else if (req_ok) g = 1;
                else if (pfq.size() > 0) g = 3;
            end
            check("req_retry", 64'(bus.drtomem_req_retry), 64'(g != 1));
            check("wb_retry", 64'(bus.drtomem_wb_retry), 64'(g != 2));
            check("pf_retry", 64'(bus.drtomem_pfreq_retry), 64'(0));

            if (bus.mem_req_valid && !bus.mem_req_retry) begin
                log_kind.push_back(bus.mem_req_kind);
                log_paddr.push_back(bus.mem_req_paddr);
            end
            req_held = bus.drtomem_req_valid && g != 1;
            wb_held  = bus.drtomem_wb_valid && g != 2;

            if (free_s) begin
                m_vld = (g != 0);
                if (g == 1) begin
                    m_kind = MK_REQ; m_drid = bus.drtomem_req_drid; m_cmd = bus.drtomem_req_cmd;
                    m_paddr = bus.drtomem_req_paddr; m_line = '0;
                end else if (g == 2) begin
                    m_kind = MK_WB; m_drid = '0; m_cmd = '0;
                    m_paddr = bus.drtomem_wb_paddr; m_line = bus.drtomem_wb_line;
                end else if (g == 3) begin
                    m_kind = MK_PF; m_drid = '0; m_cmd = '0; m_paddr = pfq[0]; m_line = '0;
                end
            end
            if (g == 1 && !ack_x) m_credits--;
            else if (g != 1 && ack_x && m_credits < MAX_OUTST) m_credits++;
            if (!bus.drtomem_req_valid || g == 1) m_wbcnt = 0;
            else if (g == 2 && req_ok && m_wbcnt < WB_BURST) m_wbcnt++;
            if (g == 3) void'(pfq.pop_front());
            if (bus.drtomem_pfreq_valid) begin
                if (pfq.size() == PF_DEPTH) begin
                    void'(pfq.pop_front());
                    if (m_drops < 65535) m_drops++;
                end
                pfq.push_back(bus.drtomem_pfreq_paddr);
            end
        end
    end

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic clear_inputs();
        bus.drtomem_req_valid = 0; bus.drtomem_wb_valid = 0; bus.drtomem_pfreq_valid = 0;
        bus.memtodr_ack_valid = 0; bus.memtodr_ack_retry = 0; bus.mem_req_retry = 0;
    endtask

    task automatic drive(input int preq, input int pwb, input int ppf, input int pack, input int pmr);
        @(posedge clk); #1;
        if (!req_held) begin
            bus.drtomem_req_valid = pct(preq);
            bus.drtomem_req_drid  = DR_reqid_type'($urandom);
            bus.drtomem_req_cmd   = SC_cmd_type'($urandom);
            bus.drtomem_req_paddr = SC_paddr_type'($urandom);
        end
        if (!wb_held) begin
            bus.drtomem_wb_valid = pct(pwb);
            bus.drtomem_wb_paddr = SC_paddr_type'($urandom);
            bus.drtomem_wb_line  = {$urandom, $urandom};
        end
        if (pf_list.size() > 0) begin
            bus.drtomem_pfreq_valid = 1;
            bus.drtomem_pfreq_paddr = pf_list.pop_front();
        end else begin
            bus.drtomem_pfreq_valid = pct(ppf);
            bus.drtomem_pfreq_paddr = SC_paddr_type'($urandom);
        end
        bus.memtodr_ack_valid = pct(pack) && (m_credits < MAX_OUTST);
        bus.memtodr_ack_retry = (pack >= 100) ? 1'b0 : ($urandom_range(3) == 0);
        bus.mem_req_retry     = pct(pmr);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    DR_memkind_type exp1[6] = '{MK_WB, MK_WB, MK_WB, MK_WB, MK_REQ, MK_WB};
    SC_paddr_type   p9, wb3_paddr, hold_paddr;
    SC_line_type    hold_line;
    SC_paddr_type   pfo[$];
    int             cfg[5][5] = '{'{60, 40, 50, 40, 30}, '{90, 90, 80, 60, 10}, '{30, 20, 90, 70, 60},
                                  '{100, 60, 30, 30, 0}, '{50, 90, 100, 50, 40}};

    initial begin
        clear_inputs();
        bus.drtomem_req_drid = '0; bus.drtomem_req_cmd = '0; bus.drtomem_req_paddr = '0;
        bus.drtomem_wb_paddr = '0; bus.drtomem_wb_line = '0; bus.drtomem_pfreq_paddr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        // WB burst limit then REQ
        log_kind.delete(); log_paddr.delete();
        repeat (6) drive(100, 100, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_order%0d", i), (i < log_kind.size()) ? 64'(log_kind[i]) : 64'hF,
                  64'(exp1[i]));
        repeat (3) drive(0, 0, 0, 0, 0);

        // credit exhaustion, hold, ack with same-cycle grant at zero credits
        do_reset();
        log_kind.delete(); log_paddr.delete();
        repeat (8) drive(100, 0, 0, 0, 0);
        drive(100, 0, 0, 0, 0);
        p9 = bus.drtomem_req_paddr;
        repeat (2) drive(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        check("t2_held_retry", 64'(bus.drtomem_req_retry), 64'(1));
        check("t2_zero_credits", 64'(dut.credits), 64'(0));
        drive(0, 0, 0, 100, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        check("t2_ninth_valid", 64'(bus.mem_req_valid), 64'(1));
        check("t2_ninth_kind", 64'(bus.mem_req_kind), 64'(MK_REQ));
        check("t2_ninth_paddr", 64'(bus.mem_req_paddr), 64'(p9));
        check("t2_credits_stay0", 64'(dut.credits), 64'(0));
        check("t2_issued", 64'(log_kind.size()), 64'(9));

        // prefetch overflow drops oldest
        do_reset();
        log_kind.delete(); log_paddr.delete();
        for (int i = 0; i < 6; i++) pf_list.push_back(32'h0000_1000 + 32'(i) * 32'h40);
        repeat (6) drive(0, 100, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t3_drops", 64'(dut.pf_drop_cnt), 64'(2));
        repeat (5) drive(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        pfo.delete();
        foreach (log_kind[i]) if (log_kind[i] == MK_PF) pfo.push_back(log_paddr[i]);
        check("t3_pf_count", 64'(pfo.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_pf%0d", i), (i < pfo.size()) ? 64'(pfo[i]) : 64'hDEAD,
                  64'(32'h0000_1000 + 32'(i + 2) * 32'h40));
        check("t3_empty", 64'(dut.u_pf.empty), 64'(1));

        // stall on a WB beat, then reset mid-stall
        do_reset();
        repeat (2) drive(100, 0, 0, 0, 0);
        drive(0, 100, 0, 0, 0);
        wb3_paddr = bus.drtomem_wb_paddr;
        for (int i = 0; i < 5; i++) begin
            drive(100, 100, 100, 0, 100);
            @(negedge clk); #1;
            if (i == 0) begin
                hold_paddr = bus.mem_req_paddr;
                hold_line  = bus.mem_req_line;
                check("t4_wb_paddr", 64'(bus.mem_req_paddr), 64'(wb3_paddr));
            end else begin
                check("t4_hold_paddr", 64'(bus.mem_req_paddr), 64'(hold_paddr));
                check("t4_hold_line", 64'(bus.mem_req_line), 64'(hold_line));
            end
            check("t4_hold_kind", 64'(bus.mem_req_kind), 64'(MK_WB));
            check("t4_req_retry", 64'(bus.drtomem_req_retry), 64'(1));
            check("t4_wb_retry", 64'(bus.drtomem_wb_retry), 64'(1));
        end
        check("t4_credits", 64'(dut.credits), 64'(6));
        check("t4_pf_nonempty", 64'(dut.u_pf.empty), 64'(0));
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk); #1;
        check("t5_valid", 64'(bus.mem_req_valid), 64'(0));
        check("t5_credits", 64'(dut.credits), 64'(MAX_OUTST));
        check("t5_empty", 64'(dut.u_pf.empty), 64'(1));
        @(posedge clk); #1;
        clear_inputs();
        reset = 1;

        // random traffic
        for (int s = 0; s < 5; s++)
            repeat (600) drive(cfg[s][0], cfg[s][1], cfg[s][2], cfg[s][3], cfg[s][4]);
        repeat (20) drive(0, 0, 0, 50, 0);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
